vermicel_divider: RTL

//   Iterative RV32M divide unit (DIV, DIVU, REM, REMU) in the execute stage.

---
 rtl/vermicel_pkg.sv | 27 ++
 rtl/vermicel_divider_if.sv | 35 +++
 rtl/vermicel_div_step.sv | 30 +++
 rtl/vermicel_divider.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/vermicel_pkg.sv
// ============================================================================
// Module : vermicel_pkg
// Brief  : Shared types and constants for the Vermicel core datapath.
// Rev    : 1.0  initial divide-unit additions
// ============================================================================
`default_nettype none

package vermicel_pkg;

  localparam int WORD_WIDTH = 32;

  typedef logic [WORD_WIDTH-1:0] word_t;

  // Decoder maps funct3 100..111 onto these in order.
  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'd0,
    DIV_OP_DIVU = 2'd1,
    DIV_OP_REM  = 2'd2,
    DIV_OP_REMU = 2'd3
  } div_op_t;

  // Cycles from accept to result for a non-special division.
  localparam int DIV_LATENCY = WORD_WIDTH + 2;

endpackage

`default_nettype wire

// File: rtl/vermicel_divider_if.sv
// ============================================================================
// Module : vermicel_divider_if
// Brief  : Request/response bundle between the execute stage and the divider.
// Rev    : 1.0  initial
// ============================================================================
`default_nettype none

interface vermicel_divider_if
  import vermicel_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic             start;
  logic             cancel;
  div_op_t          op;
  logic [WIDTH-1:0] xs1;
  logic [WIDTH-1:0] xs2;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] result;

  modport master (
    output start, cancel, op, xs1, xs2,
    input  ready, valid, result
  );

  modport slave (
    input  start, cancel, op, xs1, xs2,
    output ready, valid, result
  );

endinterface

`default_nettype wire

// File: rtl/vermicel_div_step.sv
// ============================================================================
// Module : vermicel_div_step
// Brief  : One combinational radix-2 restoring division step.
// Rev    : 1.0  initial
// ============================================================================
`default_nettype none

module vermicel_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             quot_bit
);

  logic [WIDTH:0] w_trial;
  logic [WIDTH:0] w_diff;

  // With rem_in < divisor the trial is below 2*divisor, so the top bit of the
  // WIDTH+1-bit difference is exactly the borrow-out of the comparison.
  assign w_trial  = {rem_in, dividend_msb};
  assign w_diff   = w_trial - {1'b0, divisor};
  assign quot_bit = ~w_diff[WIDTH];
  assign rem_out  = quot_bit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/vermicel_divider.sv
// ============================================================================
// Module : vermicel_divider
// Brief  : Iterative RV32M DIV/DIVU/REM/REMU unit, one quotient bit per cycle.
// Rev    : 1.0  initial
// ============================================================================
`default_nettype none

module vermicel_divider
  import vermicel_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  vermicel_divider_if.slave bus
);

  localparam int             CW           = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  c_count_init = CW'(WIDTH);
  localparam logic [CW-1:0]  c_count_one  = CW'(1);
  localparam logic [WIDTH-1:0] c_ones     = '1;
  localparam logic [WIDTH-1:0] c_min      = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  div_op_t          r_op;
  logic             r_neg_quot;
  logic             r_neg_rem;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_count;

  logic             w_accept;
  logic             w_signed;
  logic             w_div_zero;
  logic             w_overflow;
  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;
  logic [WIDTH-1:0] w_special_result;
  logic [WIDTH-1:0] w_fixup_result;
  logic [WIDTH-1:0] w_step_rem;
  logic             w_step_quot;

  assign w_accept   = bus.start && (r_state == ST_IDLE) && !bus.cancel;
  assign w_signed   = (bus.op == DIV_OP_DIV) || (bus.op == DIV_OP_REM);
  assign w_div_zero = (bus.xs2 == '0);
  assign w_overflow = w_signed && (bus.xs1 == c_min) && (bus.xs2 == c_ones);
  assign w_abs1     = (w_signed && bus.xs1[WIDTH-1]) ? -bus.xs1 : bus.xs1;
  assign w_abs2     = (w_signed && bus.xs2[WIDTH-1]) ? -bus.xs2 : bus.xs2;

  always_comb begin
    w_special_result = '0;
    if (w_div_zero) begin
      w_special_result = ((bus.op == DIV_OP_DIV) || (bus.op == DIV_OP_DIVU)) ? c_ones : bus.xs1;
    end else if (w_overflow) begin
      w_special_result = (bus.op == DIV_OP_DIV) ? c_min : '0;
    end
  end

  always_comb begin
    w_fixup_result = r_rem;
    case (r_op)
      DIV_OP_DIV:  w_fixup_result = r_neg_quot ? -r_quot : r_quot;
      DIV_OP_DIVU: w_fixup_result = r_quot;
      DIV_OP_REM:  w_fixup_result = r_neg_rem ? -r_rem : r_rem;
      default:     w_fixup_result = r_rem;
    endcase
  end

  vermicel_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in       (r_rem),
    .dividend_msb (r_dividend[WIDTH-1]),
    .divisor      (r_divisor),
    .rem_out      (w_step_rem),
    .quot_bit     (w_step_quot)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    bus.ready    = 1'b0;
    bus.valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.ready = 1'b1;
        if (w_accept) w_next_state = (w_div_zero || w_overflow) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (bus.cancel)                 w_next_state = ST_IDLE;
        else if (r_count == c_count_one) w_next_state = ST_FIXUP;
      end
      ST_FIXUP: w_next_state = bus.cancel ? ST_IDLE : ST_DONE;
      ST_DONE: begin
        bus.valid    = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign bus.result = r_result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op       <= DIV_OP_DIV;
      r_neg_quot <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_result   <= '0;
      r_count    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op       <= bus.op;
            r_neg_quot <= w_signed && (bus.xs1[WIDTH-1] ^ bus.xs2[WIDTH-1]);
            r_neg_rem  <= w_signed && bus.xs1[WIDTH-1];
            r_dividend <= w_abs1;
            r_divisor  <= w_abs2;
            r_rem      <= '0;
            r_quot     <= '0;
            r_count    <= c_count_init;
            if (w_div_zero || w_overflow) r_result <= w_special_result;
          end
        end
        ST_RUN: begin
          r_rem      <= w_step_rem;
          r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
          r_quot     <= {r_quot[WIDTH-2:0], w_step_quot};
          r_count    <= r_count - c_count_one;
        end
        // A flush here must leave the previously published result intact.
        ST_FIXUP: begin
          if (!bus.cancel) r_result <= w_fixup_result;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
